mem_bus_arbiter: RTL

- N-master, byte-wide memory/IO bus arbiter and address decoder.
- Sits between the CPU and debug masters and the shared RAM plus IO block.
- Generalises the fixed two-way CPU/debug mux with parametrised master count, round-robin arbitration, multi-byte locked bursts, tracked one-cycle read returns and a debug-pause override.

---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/mem_bus_arbiter_if.sv | 44 ++++
 rtl/mem_bus_arbiter_rr_arbiter.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and helpers for the memory/IO bus arbiter.
// Optional perf counters are enabled by defining MEM_BUS_ARBITER_PERF_EN.
package mem_bus_pkg;

    localparam logic [1:0] IO_REGION = 2'b11;
    localparam logic       ACC_READ  = 1'b0;
    localparam logic       ACC_WRITE = 1'b1;
    localparam int         CNT_W     = 32;

    // Master-index width; a single master still needs one bit to index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/grant bus and RAM/IO-side access bus of the arbiter.
// Masters hold m_req_in until m_gnt_out; the grant cycle performs the access, reads return m_rvalid_out one cycle later.
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_SEL_WIDTH   = 3
);
    logic [NUM_MASTERS-1:0]            m_req_in;
    logic [NUM_MASTERS-1:0]            m_wr_in;
    logic [NUM_MASTERS-1:0]            m_lock_in;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in;
    logic [NUM_MASTERS*8-1:0]          m_dout_in;
    logic [NUM_MASTERS-1:0]            m_gnt_out;
    logic [NUM_MASTERS-1:0]            m_rvalid_out;
    logic [7:0]                        m_din_out;

    logic                      ram_en_out;
    logic                      ram_wr_out;
    logic [RAM_ADDR_WIDTH-1:0] ram_a_out;
    logic [7:0]                ram_d_out;
    logic [7:0]                ram_d_in;

    logic                    io_en_out;
    logic                    io_wr_out;
    logic [IO_SEL_WIDTH-1:0] io_sel_out;
    logic [7:0]              io_d_out;
    logic [7:0]              io_d_in;

    modport master (
        output m_req_in, m_wr_in, m_lock_in, m_a_in, m_dout_in, ram_d_in, io_d_in,
        input  m_gnt_out, m_rvalid_out, m_din_out,
        input  ram_en_out, ram_wr_out, ram_a_out, ram_d_out,
        input  io_en_out, io_wr_out, io_sel_out, io_d_out
    );

    modport slave (
        input  m_req_in, m_wr_in, m_lock_in, m_a_in, m_dout_in, ram_d_in, io_d_in,
        output m_gnt_out, m_rvalid_out, m_din_out,
        output ram_en_out, ram_wr_out, ram_a_out, ram_d_out,
        output io_en_out, io_wr_out, io_sel_out, io_d_out
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr, modulo NUM_REQ.
module rr_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               mask,
    input  logic [idx_width(NUM_REQ)-1:0]    ptr,
    output logic [NUM_REQ-1:0]               gnt
);

    logic found;

    // Outer loop walks priority order from ptr; inner loop finds the master at that slot.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && mask[j] && (j == (int'(ptr) + i) % NUM_REQ)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master byte-wide bus arbiter with RAM/IO decode, locked bursts, pause override and tracked read returns.
// Define MEM_BUS_ARBITER_PERF_EN to build per-master saturating grant/stall counters.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_SEL_WIDTH   = 3
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         pause_in,
    mem_bus_arbiter_if.slave             bus,
    output logic [NUM_MASTERS*CNT_W-1:0] perf_gnt_cnt_out,
    output logic [NUM_MASTERS*CNT_W-1:0] perf_stall_cnt_out
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    typedef logic [IDX_W-1:0] idx_t;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] wr;
    logic [NUM_MASTERS-1:0] lock;
    logic [NUM_MASTERS-1:0] gnt;
    logic [NUM_MASTERS-1:0] pause_mask;
    logic [NUM_MASTERS-1:0] lock_mask;
    logic [NUM_MASTERS-1:0] elig_mask;

    idx_t rr_ptr;
    idx_t ptr_next;
    idx_t lock_owner;
    idx_t rd_owner;
    idx_t sel_idx;
    logic lock_valid;
    logic lock_hold;
    logic rd_pending;
    logic rd_io;
    logic [7:0] din_q;
    logic [7:0] rd_data;

    logic                  gnt_any;
    logic                  sel_wr;
    logic                  sel_lock;
    logic                  sel_io;
    logic [ADDR_WIDTH-1:0] sel_a;
    logic [7:0]            sel_dout;
    logic                  unused_addr_bits;

    assign req  = bus.m_req_in;
    assign wr   = bus.m_wr_in;
    assign lock = bus.m_lock_in;

    // The lock only survives while its owner keeps both req and lock; pause revokes any non-zero owner.
    always_comb begin
        lock_hold = lock_valid && req[lock_owner] && lock[lock_owner];
        if (pause_in && (lock_owner != '0)) begin
            lock_hold = 1'b0;
        end
    end

    always_comb begin
        pause_mask = pause_in ? NUM_MASTERS'(1) : '1;
        lock_mask  = '1;
        if (lock_hold) begin
            lock_mask             = '0;
            lock_mask[lock_owner] = 1'b1;
        end
        elig_mask = pause_mask & lock_mask;
    end

    rr_arbiter #(
        .NUM_REQ(NUM_MASTERS)
    ) u_rr_arbiter (
        .req  (req),
        .mask (elig_mask),
        .ptr  (rr_ptr),
        .gnt  (gnt)
    );

    always_comb begin
        gnt_any  = |gnt;
        sel_idx  = '0;
        sel_a    = '0;
        sel_wr   = ACC_READ;
        sel_lock = 1'b0;
        sel_dout = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gnt[k]) begin
                sel_idx  = idx_t'(k);
                sel_a    = bus.m_a_in[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wr   = wr[k];
                sel_lock = lock[k];
                sel_dout = bus.m_dout_in[k*8 +: 8];
            end
        end
    end

    assign sel_io           = (sel_a[RAM_ADDR_WIDTH -: 2] == IO_REGION);
    assign unused_addr_bits = ^sel_a[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1];
    assign ptr_next         = (sel_idx == idx_t'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        bus.m_gnt_out  = gnt;
        bus.ram_en_out = 1'b0;
        bus.ram_wr_out = 1'b0;
        bus.ram_a_out  = '0;
        bus.ram_d_out  = '0;
        bus.io_en_out  = 1'b0;
        bus.io_wr_out  = 1'b0;
        bus.io_sel_out = '0;
        bus.io_d_out   = '0;
        if (gnt_any) begin
            if (sel_io) begin
                bus.io_en_out  = 1'b1;
                bus.io_wr_out  = (sel_wr == ACC_WRITE);
                bus.io_sel_out = sel_a[IO_SEL_WIDTH-1:0];
                bus.io_d_out   = sel_dout;
            end else begin
                bus.ram_en_out = 1'b1;
                bus.ram_wr_out = (sel_wr == ACC_WRITE);
                bus.ram_a_out  = sel_a[RAM_ADDR_WIDTH-1:0];
                bus.ram_d_out  = sel_dout;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
            rd_io      <= 1'b0;
            din_q      <= '0;
        end else begin
            lock_valid <= gnt_any && sel_lock;
            if (gnt_any && sel_lock) begin
                lock_owner <= sel_idx;
            end
            if (gnt_any && !sel_lock) begin
                rr_ptr <= ptr_next;
            end
            rd_pending <= gnt_any && (sel_wr == ACC_READ);
            if (gnt_any) begin
                rd_owner <= sel_idx;
                rd_io    <= sel_io;
            end
            if (rd_pending) begin
                din_q <= rd_data;
            end
        end
    end

    // Return data is forwarded in the return cycle and held in din_q afterwards.
    assign rd_data       = rd_io ? bus.io_d_in : bus.ram_d_in;
    assign bus.m_din_out = rd_pending ? rd_data : din_q;

    always_comb begin
        bus.m_rvalid_out = '0;
        if (rd_pending) begin
            bus.m_rvalid_out[rd_owner] = 1'b1;
        end
    end

`ifdef MEM_BUS_ARBITER_PERF_EN
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_perf
        logic [CNT_W-1:0] gnt_cnt;
        logic [CNT_W-1:0] stall_cnt;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                gnt_cnt   <= '0;
                stall_cnt <= '0;
            end else begin
                if (gnt[k] && (gnt_cnt != '1)) begin
                    gnt_cnt <= gnt_cnt + 1'b1;
                end
                if (req[k] && !gnt[k] && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end

        assign perf_gnt_cnt_out[k*CNT_W +: CNT_W]   = gnt_cnt;
        assign perf_stall_cnt_out[k*CNT_W +: CNT_W] = stall_cnt;
    end
`else
    assign perf_gnt_cnt_out   = '0;
    assign perf_stall_cnt_out = '0;
`endif

endmodule
